// File: rtl/fetch_unit.sv
// Instruction fetch stage: fetches on INSTR-phase cycles, presents the fetched
// word on the following DATA-phase cycle, and handles stalls, redirects and halt.
module fetch_unit #(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_phase,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_target,
  input  logic              halt,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  output logic [7:0]        miss_count,
  output logic              phase_err
);

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_ISSUE,
    ST_BUBBLE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pend_target;
  logic              pend;

  assign mem_addr = pc;
  assign mem_req  = instr_phase & ~halt & rst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_FETCH;
      pc          <= RESET_PC;
      pend_target <= '0;
      pend        <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      miss_count  <= '0;
      phase_err   <= 1'b0;
    end else if (instr_phase) begin
      // An INSTR cycle outside ST_FETCH is flagged but still handled as a fetch.
      if (state != ST_FETCH)
        phase_err <= 1'b1;
      if (pc_load || pend) begin
        pc          <= pc_load ? pc_target : pend_target;
        pend        <= 1'b0;
        state       <= ST_BUBBLE;
        instr_valid <= 1'b0;
      end else if (halt) begin
        state       <= ST_BUBBLE;
        instr_valid <= 1'b0;
      end else if (mem_ready) begin
        instr       <= mem_rdata;
        instr_pc    <= pc;
        pc          <= pc + ADDR_W'(1);
        state       <= ST_ISSUE;
        instr_valid <= 1'b1;
      end else begin
        if (miss_count != 8'hFF)
          miss_count <= miss_count + 8'd1;
        state       <= ST_BUBBLE;
        instr_valid <= 1'b0;
      end
    end else begin
      // DATA cycle: legal only after a fetch; a redirect here waits for the next INSTR cycle.
      if (state == ST_FETCH)
        phase_err <= 1'b1;
      if (pc_load) begin
        pend_target <= pc_target;
        pend        <= 1'b1;
      end
      state       <= ST_FETCH;
      instr_valid <= 1'b0;
    end
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage driven by `controller`'s `instr_phase`. During each INSTR-phase cycle it presents the program counter to instruction memory, captures the returned word into the instruction register, and advances the PC. During the following DATA-phase cycle it presents that instruction, tagged valid, to the execute stage. It also handles memory stalls, PC redirects (branches/jumps), halt, and checks that the phase stream is legal.

## Interface
- `ADDR_W`, default 16: PC / instruction-memory word-address width.
- `DATA_W`, default 32: instruction width.
- `RESET_PC`, default 0: PC value after reset.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous and active-low.
- `instr_phase` in 1: from `controller`; 1 = INSTR cycle, 0 = DATA cycle.
- `mem_addr` out ADDR_W: instruction fetch address; equals `pc`.
- `mem_req` out 1: fetch request; `instr_phase & ~halt & rst`, combinational.
- `mem_rdata` in DATA_W: instruction word; valid in the same cycle as `mem_req` when `mem_ready` = 1.
- `mem_ready` in 1: memory has returned `mem_rdata` this cycle.
- `pc_load` in 1: redirect request; one-cycle pulse, accepted in any cycle.
- `pc_target` in ADDR_W: redirect target, sampled with `pc_load`.
- `halt` in 1: level; suppresses fetches while high.
- `instr` out DATA_W: instruction register.
- `instr_pc` out ADDR_W: address `instr` was fetched from.
- `instr_valid` out 1: `instr` is a live instruction; high for exactly one DATA cycle.
- `miss_count` out 8: saturating count of INSTR cycles with `mem_req` = 1 and `mem_ready` = 0.
- `phase_err` out 1: sticky flag for an illegal phase sequence.

## Operation
- Reset values: `pc` = RESET_PC; `instr`, `instr_pc`, `miss_count` = 0; `instr_valid`, `phase_err` = 0; redirect-pending cleared; FSM = ST_FETCH. `mem_req` = 0 while `rst` = 0.
- FSM states:
  - ST_FETCH: expecting an INSTR cycle.
  - ST_ISSUE: DATA cycle with `instr_valid` = 1.
  - ST_BUBBLE: DATA cycle with `instr_valid` = 0.
- ST_FETCH with `instr_phase` = 1 resolves in this priority order:
  1. **Redirect:** `pc_load` this cycle, or pending set. Set `pc` to the target; `pc_target` this cycle wins over the stored pending target. Clear pending, discard `mem_rdata`, go to ST_BUBBLE. Redirect applies even while `halt` = 1.
  2. **Halt:** `halt` = 1. No request; `pc` held; go to ST_BUBBLE.
  3. **Fetch hit:** `mem_ready` = 1. Set `instr` = `mem_rdata`, `instr_pc` = `pc`, `pc` = `pc`+1 (modulo 2^ADDR_W, so all-ones wraps to 0); go to ST_ISSUE.
  4. **Miss:** otherwise. `pc` held (retried next INSTR cycle); `miss_count` += 1, saturating at 255; go to ST_BUBBLE.
- ST_ISSUE / ST_BUBBLE with `instr_phase` = 0:
  - Return to ST_FETCH.
  - If `pc_load` = 1, store `pc_target` and set pending; a later `pc_load` before consumption overwrites the stored target.
  - `instr` and `instr_pc` are held.
- `instr_valid` is 1 only while in ST_ISSUE.
- Phase check:
  - `instr_phase` = 0 in ST_FETCH: set `phase_err`, stay in ST_FETCH, no fetch. A `pc_load` in that cycle is stored as pending.
  - `instr_phase` = 1 in ST_ISSUE/ST_BUBBLE: set `phase_err`, then process as an ST_FETCH cycle.
  - `phase_err` clears only on reset.
- Reset asserted mid-operation: all registers return to reset values immediately and asynchronously; any in-flight fetch and any pending redirect are dropped.

## Timing
- Fetch latency: memory returns the word in the INSTR cycle; `instr`/`instr_valid` are visible the next cycle (DATA) and are consumed at the end of that cycle.
- Throughput: one instruction per INSTR/DATA pair with no misses.
- Redirect latency:
  - `pc_load` in an INSTR cycle: first fetch from the target is in the next INSTR cycle, two cycles later.
  - `pc_load` in a DATA cycle: the target is fetched in the immediately following INSTR cycle? No — that INSTR cycle loads `pc`, and the fetch from the target occurs in the INSTR cycle after it.
  - In both cases the redirecting cycle produces exactly one bubble.
- `mem_addr` changes only on clock edges; `mem_req` follows `instr_phase` and `halt` combinationally.

## Test plan
- **Straight-line fetch:** reset with RESET_PC = 0x0010, memory always ready, mem[a] = 0xA000_0000+a → `instr_valid` pulses in every DATA cycle; `instr` = 0xA000_0010, 0xA000_0011, 0xA000_0012; `instr_pc` matches.
- **Miss/retry:** `mem_ready` = 0 in the INSTR cycle at `pc` = 0x0012 → bubble (`instr_valid` = 0); `miss_count` = 1; next INSTR cycle fetches 0x0012 again. Hold `mem_ready` = 0 for 300 INSTR cycles → `miss_count` = 255.
- **Redirect in INSTR cycle:** `pc_load` = 1, `pc_target` = 0x0100 while `mem_ready` = 1 → fetched word discarded, bubble, next `instr_pc` = 0x0100. Redirect in a DATA cycle to 0x0200 → one bubble, then `instr_pc` = 0x0200.
- **Wrap and halt:** RESET_PC = 0xFFFF → `instr_pc` 0xFFFF then 0x0000. `halt` high for 3 pairs → `mem_req` = 0 and no `instr_valid`; `pc` unchanged; fetch resumes at the same `pc`.
- **Phase error:** drive `instr_phase` = 1 for two consecutive cycles → `phase_err` = 1 and remains 1 until `rst` low.
- **Reset mid-operation:** assert `rst` low with a pending redirect → all outputs return to reset values; after release, first fetch is at RESET_PC, not the old target.
